// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default byte width and an index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;

  // Width needed to hold an index into n items, never less than one bit.
  function automatic int log2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: grants the first set request at or above ptr,
// wrapping at N. Purely combinational so other arbiters can reuse it.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = log2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int            j;
  logic [IW-1:0] jj;

  // Scan from the farthest slot back toward ptr so the nearest request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (req[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. One byte is in
// flight at a time; a multi-byte message keeps the grant until its last byte.
//
// Handshake: a requester holds req_valid with stable req_data/req_last until
// it sees req_ready; the byte is taken on the rising edge where both are high.
// req_ready is only ever raised in ARB while the transmitter is idle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int BUSY_TO    = 8,
  localparam int IW         = log2w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [IW-1:0]                 owner,
  output logic                          locked,
  output logic                          err,
  output state_t                        state_dbg
);

  localparam int CW = log2w(BUSY_TO) + 1;

  state_t             state, state_nx;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win;
  logic               accept;
  logic               timeout;

  assign state_dbg = state;

  // While a message is open only its owner may compete.
  always_comb begin
    elig = req_valid;
    if (locked) elig = req_valid & (NUM_REQ'(1) << owner);
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  // Next-state logic, ready/start generation and timeout detection.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    tx_start  = 1'b0;
    accept    = 1'b0;
    timeout   = 1'b0;
    case (state)
      ARB: begin
        if (!tx_busy) begin
          req_ready = grant;
          if (|grant) begin
            accept   = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        state_nx = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nx = WAIT_LO;
        end else if (cnt == CW'(BUSY_TO - 1)) begin
          // Transmitter never acknowledged; the byte is dropped, not retried.
          timeout  = 1'b1;
          state_nx = ARB;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  // Byte latch, ownership, lock, round-robin pointer, timeout counter, error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
      owner   <= '0;
      locked  <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        tx_data <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        owner   <= win;
        locked  <= ~req_last[win];
        if (req_last[win]) ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT_HI && !tx_busy && !timeout) cnt <= cnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester driver, transmitter model, scoreboard
// of expected {owner,byte} at each tx_start, and per-scenario tasks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int BT = 8;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic           tx_start;
  logic [DW-1:0]  tx_data;
  logic           tx_busy;
  logic [0:0]     owner;
  logic           locked;
  logic           err;
  state_t         state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int prot_viol = 0;
  int cyc = 0;
  int acc_cnt[NR];
  int acc_cyc[NR];
  int rdy_cnt[NR];
  int start_cyc = -1;
  int busy_low_cyc = -1;

  int model_on = 1;
  int busy_delay = 2;
  int frame_len = 10;
  int reset_hold = 5;
  int pend_m, frame_m, hold_m;

  logic [8:0] src_q[NR][$];
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [8:0] drv_h;
  bit         drv_pend[NR];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TO(BT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .owner     (owner),
    .locked    (locked),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy out of reset, rises busy_delay cycles after start,
  // stays busy frame_len cycles. model_on=0 never raises busy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b1;
      hold_m  <= reset_hold;
      pend_m  <= 0;
      frame_m <= 0;
    end else begin
      if (hold_m > 0) begin
        hold_m <= hold_m - 1;
        if (hold_m == 1) tx_busy <= 1'b0;
      end
      if (tx_start && model_on != 0) pend_m <= busy_delay;
      else if (pend_m > 0) begin
        pend_m <= pend_m - 1;
        if (pend_m == 1) begin
          tx_busy <= 1'b1;
          frame_m <= frame_len;
        end
      end
      if (frame_m > 0) begin
        frame_m <= frame_m - 1;
        if (frame_m == 1) tx_busy <= 1'b0;
      end
    end
  end

  // ---------------- requester driver ----------------
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      acc_cnt[i] = 0; acc_cyc[i] = -1; rdy_cnt[i] = 0; drv_pend[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (rst) begin
          drv_pend[i]  = 0;
          req_valid[i] = 1'b0;
        end else begin
          if (drv_pend[i]) begin
            drv_h = src_q[i].pop_front();
            acc_cnt[i]++;
            drv_pend[i] = 0;
          end
          if (src_q[i].size() != 0) begin
            drv_h = src_q[i][0];
            req_valid[i]         = 1'b1;
            req_data[i*DW +: DW] = drv_h[7:0];
            req_last[i]          = drv_h[8];
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      #1;
      for (int i = 0; i < NR; i++) begin
        if (!rst && req_valid[i] && req_ready[i]) begin
          drv_pend[i] = 1;
          acc_cyc[i]  = cyc;
        end
      end
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (req_ready != '0 && (state_dbg != ARB || tx_busy || $countones(req_ready) != 1))
        prot_viol++;
      if (tx_start) begin
        start_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte: got owner=%0d data=%02h, required no byte", owner, tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({owner, tx_data} !== mon_e) begin
            n_err++;
            $display("FAIL tx_byte: got owner=%0d data=%02h, required owner=%0d data=%02h",
                     owner, tx_data, mon_e[8], mon_e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic wait_exp_empty(input int max_cyc);
    for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      if (state_dbg == ARB && !tx_busy && src_q[0].size() == 0 && src_q[1].size() == 0) break;
      tick();
    end
    if (k == max_cyc) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got state=%0d busy=%0b, required idle", state_dbg, tx_busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    reset_hold = 5;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %02h required 00", tx_data); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL rst_owner: got %0d required 0", owner); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b required 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", err); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b required 00", req_ready); end
    n_cmp++; if (state_dbg !== ARB) begin n_err++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
    src_q[1].push_back({1'b1, 8'h41});
    exp_q.push_back({1'b1, 8'h41});
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (7) begin
      tick();
      if (tx_busy && req_ready !== 2'b00) bad++;
      if (!tx_busy && busy_low_cyc < 0) busy_low_cyc = cyc;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ready_while_busy: got %0d cycles required 0", bad); end
  endtask

  task automatic test_single_byte();
    wait_exp_empty(100);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_sent: got %0d pending required 0", exp_q.size()); end
    wait_idle(100);
    n_cmp++; if (acc_cnt[1] !== 1) begin n_err++; $display("FAIL single_acc: got %0d required 1", acc_cnt[1]); end
    n_cmp++; if (rdy_cnt[1] !== 1) begin n_err++; $display("FAIL single_ready_pulses: got %0d required 1", rdy_cnt[1]); end
    n_cmp++; if (start_cyc !== acc_cyc[1] + 1) begin n_err++; $display("FAIL start_latency: got cycle %0d required %0d", start_cyc, acc_cyc[1] + 1); end
    n_cmp++; if (acc_cyc[1] !== busy_low_cyc) begin n_err++; $display("FAIL first_grant: got cycle %0d required %0d", acc_cyc[1], busy_low_cyc); end
  endtask

  task automatic test_tie();
    frame_len = 160;
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back({1'b1, 8'hA0 + 8'(k)});
      src_q[1].push_back({1'b1, 8'hB0 + 8'(k)});
      exp_q.push_back({1'b0, 8'hA0 + 8'(k)});
      exp_q.push_back({1'b1, 8'hB0 + 8'(k)});
    end
    wait_exp_empty(1500);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL tie_sent: got %0d pending required 0", exp_q.size()); end
    wait_idle(300);
    n_cmp++; if (acc_cnt[0] !== 3) begin n_err++; $display("FAIL tie_acc0: got %0d required 3", acc_cnt[0]); end
    n_cmp++; if (acc_cnt[1] !== 4) begin n_err++; $display("FAIL tie_acc1: got %0d required 4", acc_cnt[1]); end
  endtask

  task automatic test_lock();
    int base0, base1, k2;
    frame_len = 6;
    base0 = acc_cnt[0];
    base1 = acc_cnt[1];
    src_q[0].push_back({1'b0, 8'h31});
    src_q[0].push_back({1'b0, 8'h32});
    src_q[0].push_back({1'b1, 8'h33});
    src_q[1].push_back({1'b1, 8'hC0});
    src_q[1].push_back({1'b1, 8'hC1});
    exp_q.push_back({1'b0, 8'h31});
    exp_q.push_back({1'b0, 8'h32});
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'hC0});
    exp_q.push_back({1'b1, 8'hC1});
    for (int k = 0; k < 3; k++) begin
      for (k2 = 0; k2 < 100 && acc_cnt[0] != base0 + k + 1; k2++) tick();
      n_cmp++;
      if (locked !== (k < 2)) begin
        n_err++; $display("FAIL lock_flag_%0d: got %b required %b", k, locked, (k < 2));
      end
    end
    n_cmp++; if (acc_cnt[1] !== base1) begin n_err++; $display("FAIL lock_interleave: got %0d required %0d", acc_cnt[1], base1); end
    wait_exp_empty(200);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL lock_sent: got %0d pending required 0", exp_q.size()); end
    wait_idle(100);
  endtask

  task automatic test_timeout();
    int err_cyc, k;
    model_on = 0;
    src_q[1].push_back({1'b1, 8'h77});
    exp_q.push_back({1'b1, 8'h77});
    err_cyc = -1;
    for (k = 0; k < 60; k++) begin
      tick();
      if (err === 1'b1) begin err_cyc = cyc; break; end
    end
    n_cmp++; if (err_cyc - start_cyc !== BT + 1) begin n_err++; $display("FAIL timeout_delay: got %0d cycles required %0d", err_cyc - start_cyc, BT + 1); end
    n_cmp++; if (state_dbg !== ARB) begin n_err++; $display("FAIL timeout_state: got %0d required 0", state_dbg); end
    model_on = 1;
    src_q[0].push_back({1'b1, 8'h78});
    exp_q.push_back({1'b0, 8'h78});
    wait_exp_empty(100);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL after_timeout: got %0d pending required 0", exp_q.size()); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b required 1", err); end
    wait_idle(100);
  endtask

  task automatic test_reset_midframe();
    int k;
    frame_len  = 20;
    reset_hold = 3;
    src_q[1].push_back({1'b0, 8'h98});
    src_q[1].push_back({1'b1, 8'h99});
    exp_q.push_back({1'b1, 8'h98});
    exp_q.push_back({1'b1, 8'h99});
    for (k = 0; k < 50 && state_dbg != WAIT_LO; k++) tick();
    n_cmp++; if (state_dbg !== WAIT_LO) begin n_err++; $display("FAIL reach_wait_lo: got %0d required 3", state_dbg); end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL midframe_locked: got %b required 1", locked); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (state_dbg !== ARB) begin n_err++; $display("FAIL arst_state: got %0d required 0", state_dbg); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL arst_locked: got %b required 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL arst_err: got %b required 0", err); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL arst_owner: got %0d required 0", owner); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL arst_tx_data: got %02h required 00", tx_data); end
    n_cmp++; if (tx_start !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL arst_start_ready: got %b/%b required 0/00", tx_start, req_ready); end
    tick();
    tick();
    src_q[0].delete();
    src_q[1].delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_idle(100);
    src_q[0].push_back({1'b1, 8'h5A});
    exp_q.push_back({1'b0, 8'h5A});
    wait_exp_empty(100);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL after_reset: got %0d pending required 0", exp_q.size()); end
    wait_idle(100);
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (prot_viol !== 0) begin
      n_err++; $display("FAIL ready_protocol: got %0d bad cycles required 0", prot_viol);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_tie();
    test_lock();
    test_timeout();
    test_reset_midframe();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
